// File: rtl/dp_mem_pkg.sv
// Shared types and default sizing for the dp_data_mem block.
package dp_mem_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  // Controller states: power-up/reset clear sweep, then normal operation
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } dp_mem_state_t;

endpackage

// File: rtl/dp_mem_array.sv
// Storage for dp_data_mem: one byte-enabled synchronous write port and
// one registered read port (read-first on address collision).
module dp_mem_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [DATA_W/8-1:0] wr_be_i,
  input  logic                rd_en_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  output logic [DATA_W-1:0]   rd_data_o
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Byte-lane write; contents are never reset, only overwritten by the sweep
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be_i[i]) begin
          mem_q[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
        end
      end
    end
  end

  // Registered read; holds its value when no read is accepted
  always_ff @(posedge clk) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dp_data_mem.sv
// Dual-port data memory with a zeroing sweep after reset.
// While busy the controller owns the write port and writes zero to every
// word in turn; user reads and writes are dropped until the sweep ends.
// Optional build macro: DP_DATA_MEM_RDW_FWD_EN -- when defined, a read that
// collides with a write to the same word returns the merged new word;
// otherwise the old stored word is returned (read-first).
module dp_data_mem
  import dp_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_W-1:0]   a,
  input  logic [DATA_W-1:0]   d,
  input  logic [DATA_W/8-1:0] be,
  input  logic                re,
  input  logic [ADDR_W-1:0]   dpra,
  output logic [DATA_W-1:0]   dpo,
  output logic                dpo_valid,
  output logic                busy
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  dp_mem_state_t     state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic              dpo_valid_q;

  logic              clearing;
  logic              usr_wr;
  logic              usr_rd;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NB-1:0]     wr_be;
  logic [DATA_W-1:0] rd_data;

  assign clearing = (state_q == ST_CLEAR);
  assign usr_wr   = !rst && !clearing && we;
  assign usr_rd   = !rst && !clearing && re;

  // Sweep controller: clear every word once, then hand the ports to the user
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (cnt_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Write-port mux: sweep zeroes whole words, otherwise the user port
  always_comb begin
    wr_en   = usr_wr;
    wr_addr = a;
    wr_data = d;
    wr_be   = be;
    if (clearing) begin
      wr_en   = !rst;
      wr_addr = cnt_q;
      wr_data = '0;
      wr_be   = '1;
    end
  end

  dp_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk       (clk),
    .rst_i     (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .wr_be_i   (wr_be),
    .rd_en_i   (usr_rd),
    .rd_addr_i (dpra),
    .rd_data_o (rd_data)
  );

  // Read-valid flag tracks the array's one-cycle read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      dpo_valid_q <= 1'b0;
    end else begin
      dpo_valid_q <= usr_rd;
    end
  end

`ifdef DP_DATA_MEM_RDW_FWD_EN
  logic              fwd_hit_q;
  logic [NB-1:0]     fwd_be_q;
  logic [DATA_W-1:0] fwd_d_q;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     sel
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (sel[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Remember a same-word collision so the read-first array output can be
  // patched with the bytes written in that same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_hit_q <= 1'b0;
    end else if (usr_rd) begin
      fwd_hit_q <= usr_wr && (a == dpra);
      fwd_be_q  <= be;
      fwd_d_q   <= d;
    end
  end

  assign dpo = fwd_hit_q ? merge_bytes(rd_data, fwd_d_q, fwd_be_q) : rd_data;
`else
  assign dpo = rd_data;
`endif

  assign dpo_valid = dpo_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dp_data_mem.sv
// Directed bench for dp_data_mem at ADDR_W=4, DATA_W=32 with a reference
// memory model and a queue of expected read results.
module tb_dp_data_mem;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NBT = DW / 8;
  localparam int DEP = 2 ** AW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           we = 1'b0;
  logic [AW-1:0]  a = '0;
  logic [DW-1:0]  d = '0;
  logic [NBT-1:0] be = '0;
  logic           re = 1'b0;
  logic [AW-1:0]  dpra = '0;
  logic [DW-1:0]  dpo;
  logic           dpo_valid;
  logic           busy;

  int vectors = 0;
  int errs = 0;
  logic [DW-1:0] ref_mem [DEP];
  logic [DW-1:0] exp_q [$];

  dp_data_mem #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .a         (a),
    .d         (d),
    .be        (be),
    .re        (re),
    .dpra      (dpra),
    .dpo       (dpo),
    .dpo_valid (dpo_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [NBT-1:0] s);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < NBT; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  // Advance one clock; rd says a read was accepted at this edge
  task automatic tick(input bit rd);
    logic [DW-1:0] e;
    @(posedge clk);
    #1;
    if (rd) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("dpo_valid", {31'd0, dpo_valid}, 32'd1);
        check("dpo", dpo, e);
      end
    end else begin
      check("dpo_valid_low", {31'd0, dpo_valid}, 32'd0);
    end
  endtask

  // One cycle of user traffic while the memory is idle
  task automatic cyc(input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic [NBT-1:0] wbe, input bit r, input logic [AW-1:0] ra);
    logic [DW-1:0] e;
    we = w; a = wa; d = wd; be = wbe; re = r; dpra = ra;
    if (r) begin
      e = ref_mem[ra];
`ifdef DP_DATA_MEM_RDW_FWD_EN
      if (w && wa == ra) e = merge(e, wd, wbe);
`endif
      exp_q.push_back(e);
    end
    if (w) ref_mem[wa] = merge(ref_mem[wa], wd, wbe);
    tick(r);
    we = 1'b0; re = 1'b0;
  endtask

  // Wait out a sweep with junk traffic on both ports; expect exactly n busy cycles
  task automatic sweep_wait(input int n);
    int cnt;
    cnt = 0;
    while (busy && cnt < 40) begin
      we = 1'b1; a = '0; d = 32'hFFFF_FFFF; be = '1;
      re = 1'b1; dpra = AW'($urandom_range(0, DEP - 1));
      tick(1'b0);
      cnt++;
    end
    we = 1'b0; re = 1'b0;
    check("busy_cycles", cnt, n);
    for (int i = 0; i < DEP; i++) ref_mem[i] = '0;
  endtask

  initial begin
    // Power-up reset
    rst = 1'b1;
    tick(1'b0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_dpo", dpo, 32'd0);
    rst = 1'b0;
    sweep_wait(16);
    check("busy_after_sweep", {31'd0, busy}, 32'd0);

    // Every word reads zero after the sweep
    for (int i = 0; i < DEP; i++) cyc(1'b0, '0, '0, '0, 1'b1, AW'(i));

    // Full-word write then read back
    cyc(1'b1, 4'd3, 32'hDEAD_BEEF, 4'b1111, 1'b0, '0);
    cyc(1'b0, '0, '0, '0, 1'b1, 4'd3);
    check("model_w3", ref_mem[3], 32'hDEAD_BEEF);

    // Partial byte write merges with stored bytes
    cyc(1'b1, 4'd5, 32'h1122_3344, 4'b1111, 1'b0, '0);
    cyc(1'b1, 4'd5, 32'hAABB_CCDD, 4'b0101, 1'b0, '0);
    exp_q.push_back(32'h11BB_33DD);
    re = 1'b1; dpra = 4'd5;
    tick(1'b1);
    re = 1'b0;

    // be=0 write changes nothing
    cyc(1'b1, 4'd3, 32'h0BAD_0BAD, 4'b0000, 1'b0, '0);
    cyc(1'b0, '0, '0, '0, 1'b1, 4'd3);

    // Same-word read and write in one cycle
    cyc(1'b1, 4'd7, 32'h1234_5678, 4'b1111, 1'b1, 4'd7);
    cyc(1'b0, '0, '0, '0, 1'b1, 4'd7);

    // Partial collision, then independent ports at different words
    cyc(1'b1, 4'd5, 32'h5566_7788, 4'b1010, 1'b1, 4'd5);
    cyc(1'b1, 4'd9, 32'h9999_0000, 4'b1100, 1'b1, 4'd3);
    cyc(1'b1, 4'd1, 32'h0102_0304, 4'b1111, 1'b1, 4'd9);
    cyc(1'b0, '0, '0, '0, 1'b1, 4'd5);
    cyc(1'b0, '0, '0, '0, 1'b1, 4'd1);

    // Read value holds while re stays low
    cyc(1'b1, 4'd2, 32'hCAFE_F00D, 4'b1111, 1'b0, '0);
    cyc(1'b0, '0, '0, '0, 1'b1, 4'd2);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      check("dpo_hold", dpo, 32'hCAFE_F00D);
    end

    // Reset, then reset again eight cycles into the sweep
    rst = 1'b1;
    tick(1'b0);
    check("rst2_dpo", dpo, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; a = 4'd15; d = 32'hFFFF_FFFF; be = '1; re = 1'b1; dpra = 4'd2;
      tick(1'b0);
    end
    rst = 1'b1; we = 1'b1; re = 1'b1;
    tick(1'b0);
    check("rst3_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    sweep_wait(16);

    // Nothing written during the sweep survived
    for (int i = 0; i < DEP; i++) cyc(1'b0, '0, '0, '0, 1'b1, AW'(i));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dp_data_mem.md
DP_DATA_MEM -- requirements
Module: dp_data_mem

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; depth DEPTH = 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 32, word width; SHALL be a multiple of 8; NB = DATA_W/8 byte lanes.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 we  in  1  write request.
REQ-006 a  in  ADDR_W  write word address.
REQ-007 d  in  DATA_W  write data.
REQ-008 be  in  NB  byte enables; be[i] selects d[8i+7:8i].
REQ-009 re  in  1  read request.
REQ-010 dpra  in  ADDR_W  read word address.
REQ-011 dpo  out  DATA_W  registered read data.
REQ-012 dpo_valid  out  1  dpo updated by a read this cycle.
REQ-013 busy  out  1  clear sweep in progress; requests ignored.

Function
REQ-014 FSM has two states, ST_CLEAR and ST_IDLE; reset enters ST_CLEAR with sweep counter = 0.
REQ-015 ST_CLEAR: each cycle writes all-zero to word[counter], then increments counter; after writing DEPTH-1 the FSM goes to ST_IDLE; sweep takes exactly DEPTH cycles.
REQ-016 busy = 1 exactly while in ST_CLEAR; it drops in the cycle after word DEPTH-1 is cleared.
REQ-017 In ST_CLEAR, we and re are ignored: no write, dpo holds, dpo_valid = 0.
REQ-018 In ST_IDLE with we=1: at the clock edge, word[a] byte i <= d byte i for every be[i]=1; other bytes unchanged; be=0 is a no-op.
REQ-019 In ST_IDLE with re=1 at edge n: dpo = word[dpra] and dpo_valid = 1 after edge n (1-cycle latency).
REQ-020 re=0 (or ST_CLEAR): dpo holds previous value, dpo_valid = 0.
REQ-021 Reads and writes are independent and may both occur each cycle, at any addresses.
REQ-022 Same-address read and write in one cycle: behaviour per REQ-026/REQ-027.
REQ-023 Sweep counter has ADDR_W bits and never wraps; the terminal compare is against DEPTH-1.

Reset
REQ-024 On rst=1 at an edge: dpo = 0, dpo_valid = 0, busy = 1, state = ST_CLEAR, counter = 0; pending requests are dropped.
REQ-025 rst asserted mid-sweep restarts the sweep at address 0; memory contents are not otherwise reset.

Configuration
REQ-026 Macro DP_DATA_MEM_RDW_FWD_EN defined: same-address read and write returns the merged new word (d bytes where be[i]=1, stored bytes elsewhere).
REQ-027 Macro not defined: same-address read and write returns the old stored word (read-first); the write still takes effect.

Structure
REQ-028 Package dp_mem_pkg SHALL hold the state typedef (ST_CLEAR, ST_IDLE) and default constants (ADDR_W=10, DATA_W=32).
REQ-029 Sub-module dp_mem_array SHALL hold the storage: byte-enabled write port and registered read port. The FSM, the clear mux and the forwarding logic are in dp_data_mem.

Verification (ADDR_W=4, DATA_W=32)
REQ-030 Reset pulse -> busy=1 for 16 cycles, then 0; re on each word 0..15 -> dpo=0x00000000, dpo_valid=1, one cycle after each re.
REQ-031 we=1, a=3, d=0xDEADBEEF, be=4'b1111; next cycle re=1, dpra=3 -> dpo=0xDEADBEEF one cycle later.
REQ-032 Word 5 = 0x11223344; write d=0xAABBCCDD, be=4'b0101, a=5; then read 5 -> 0x11BB33DD.
REQ-033 Word 7 = 0x0; same cycle we=1, a=7, d=0x12345678, be=4'b1111, re=1, dpra=7 -> dpo=0x12345678 with macro, 0x00000000 without; a later read returns 0x12345678 in both builds.
REQ-034 rst at sweep cycle 8 -> busy stays 1 for 16 more cycles; we/re during the sweep -> dpo_valid=0 and no write persists.
REQ-035 re=0 for 3 cycles after a read of 0xCAFEF00D -> dpo holds 0xCAFEF00D, dpo_valid=0.
